// File: rtl/regbank_wr_arbiter.sv
// Write-port controller for the register bank: zero-clears every entry after reset,
// then round-robin arbitrates the single write port between the ALU and load writeback ports.
module regbank_wr_arbiter #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int ZERO_R0 = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_dr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_dr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_dr,
    output logic [DW-1:0] wr_data,
    output logic          init_busy
);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] cnt;
    logic          ptr;
    logic          grant0;
    logic          grant1;

    // A hard-wired r0 still handshakes normally; only the bank strobe is dropped.
    function automatic logic issue_en(input logic [AW-1:0] dr);
        return !((ZERO_R0 != 0) && (dr == '0));
    endfunction

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == RUN) begin
            if (req0_valid && (!req1_valid || !ptr))
                grant0 = 1'b1;
            else if (req1_valid)
                grant1 = 1'b1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign init_busy  = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            cnt     <= '0;
            ptr     <= 1'b0;
            wr_en   <= 1'b0;
            wr_dr   <= '0;
            wr_data <= '0;
        end else if (state == CLEAR) begin
            wr_en   <= 1'b1;
            wr_dr   <= cnt;
            wr_data <= '0;
            if (cnt == AW'(NREG - 1)) begin
                state <= RUN;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (grant0) begin
            wr_en   <= issue_en(req0_dr);
            wr_dr   <= req0_dr;
            wr_data <= req0_data;
            ptr     <= 1'b1;
        end else if (grant1) begin
            wr_en   <= issue_en(req1_dr);
            wr_dr   <= req1_dr;
            wr_data <= req1_data;
            ptr     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
        end
    end

endmodule
